key_capture: RTL

//  Consumer end of the keypad scan interface: takes the active row drive, debounced column

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/key_capture_if.sv | 24 ++
 rtl/seg7_decode.sv | 9 +
 rtl/key_capture.sv | 127 ++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad and display constants: FSM state encoding, key map and seven-segment patterns.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_HOLD  = 2'd2
  } capture_state_t;

  // Indexed [row][col] with row1/col1 at index 0.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Active-low segments, bit order g..a (seg[0]=a).
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [1:0] ANODE_NEW = 2'b10;
  localparam logic [3:0] COLS_IDLE = 4'b1111;

endpackage

// File: rtl/key_capture_if.sv
// Scanner-to-capture bus. enable is a one-cycle strobe with no back-pressure: rows/columns are
// only meaningful while enable=1, and the consumer either acts on it or drops it that cycle.
interface key_capture_if;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       enable;
  logic       key_valid;
  logic       key_err;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic [1:0] anode;
  logic [6:0] seg;
  logic [1:0] state;

  modport master (
    output rows, columns, enable,
    input  key_valid, key_err, digit_new, digit_old, anode, seg, state
  );

  modport slave (
    input  rows, columns, enable,
    output key_valid, key_err, digit_new, digit_old, anode, seg, state
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex to active-low seven-segment decoder.
module seg7_decode
  import keypad_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_PAT[hex];
endmodule

// File: rtl/key_capture.sv
// Keypad consumer: decodes single-key presses, locks out until release, keeps a two-digit
// history and multiplexes it onto a two-anode seven-segment display.
module key_capture
  import keypad_pkg::*;
#(
  parameter int RELEASE_CYCLES = 16,
  parameter int MUX_DIV        = 24000
) (
  input logic          clk,
  input logic          reset,
  key_capture_if.slave bus
);

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int MUX_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [MUX_W-1:0] MUX_LAST = MUX_W'(MUX_DIV - 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] LATCH = ST_LATCH;
  localparam logic [1:0] HOLD  = ST_HOLD;

  logic [1:0]       state;
  logic [3:0]       key_reg;
  logic [3:0]       digit_new;
  logic [3:0]       digit_old;
  logic             key_valid;
  logic             key_err;
  logic [REL_W-1:0] rel_cnt;
  logic [MUX_W-1:0] mux_cnt;
  logic [1:0]       anode;

  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       press_ok;
  logic       cols_idle;
  logic [3:0] decoded;
  logic [3:0] shown_digit;

  // rows[3]/columns[3] are row1/col1, hence the reversed index.
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rows[i])     row_idx = 2'(3 - i);
      if (!bus.columns[i]) col_idx = 2'(3 - i);
    end
  end

  assign press_ok  = $onehot(bus.rows) && $onehot(~bus.columns);
  assign cols_idle = (bus.columns == COLS_IDLE);
  assign decoded   = KEY_MAP[row_idx][col_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      key_reg   <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      rel_cnt   <= '0;
    end else begin
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (press_ok) begin
              key_reg <= decoded;
              state   <= LATCH;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        LATCH: begin
          digit_old <= digit_new;
          digit_new <= key_reg;
          key_valid <= 1'b1;
          rel_cnt   <= '0;
          state     <= HOLD;
        end
        HOLD: begin
          // Any bounce restarts the release window; strobes here are deliberately ignored.
          if (!cols_idle) begin
            rel_cnt <= '0;
          end else if (rel_cnt == REL_LAST) begin
            rel_cnt <= '0;
            state   <= IDLE;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display scan runs free of the capture FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_cnt <= '0;
      anode   <= ANODE_NEW;
    end else if (mux_cnt == MUX_LAST) begin
      mux_cnt <= '0;
      anode   <= ~anode;
    end else begin
      mux_cnt <= mux_cnt + 1'b1;
    end
  end

  assign shown_digit = (anode == ANODE_NEW) ? digit_new : digit_old;

  seg7_decode u_seg7 (
    .hex (shown_digit),
    .seg (bus.seg)
  );

  assign bus.key_valid = key_valid;
  assign bus.key_err   = key_err;
  assign bus.digit_new = digit_new;
  assign bus.digit_old = digit_old;
  assign bus.anode     = anode;
  assign bus.state     = state;

endmodule
